apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Shares the single APB_BUS master between NUM_REQ requesters (e.g. CPU port, DMA port), using round-robin arbitration.
- Accepts one command from the winning requester and drives the master's transfer-side inputs (Transfer, IN_ADDR, IN_DATA, IN_WRITE, IN_STRB).
- Observes bus completion (PENABLE && PREADY) and returns read data and error to the granted requester.
- Sits between the requesters and APB_BUS; the GPIO/UART slaves see no change.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, APB address width
DATA_WIDTH, 32, APB data width
STRB_WIDTH, 4, byte strobe width (DATA_WIDTH/8)
TIMEOUT_CYCLES, 16, WAIT-state cycles before wait_timeout asserts (>=2)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write  in  NUM_REQ  1=write, 0=read
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_strb  in  NUM_REQ*STRB_WIDTH  flattened strobes
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data of last completed transfer
rsp_slverr  out  1  PSLVERR of last completed transfer
Transfer  out  1  to APB_BUS, start request
IN_ADDR  out  ADDR_WIDTH  to APB_BUS
IN_DATA  out  DATA_WIDTH  to APB_BUS
IN_WRITE  out  1  to APB_BUS
IN_STRB  out  STRB_WIDTH  to APB_BUS
PENABLE  in  1  from APB_BUS
PREADY  in  1  from slave mux
PRDATA  in  DATA_WIDTH  from slave mux
PSLVERR  in  1  from slave mux
busy  out  1  high in any state other than IDLE
wait_timeout  out  1  high while the WAIT count is >= TIMEOUT_CYCLES

Behaviour:
- Reset (PRESET=1 at an edge), including mid-transfer:
  - state=IDLE, rr_ptr=0, and all outputs 0 (Transfer, IN_*, req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, wait_timeout).
  - APB_BUS is reset by the same event (driven as ~PRESET at top level); no transfer resumes.
- States: IDLE, ISSUE, WAIT, RESP, encoded 2 bits.
- IDLE:
  - If |req_valid, the winner is the first set bit searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally in this cycle.
  - At the edge: latch addr, wdata, write and strb into the IN_* registers, store grant index, go to ISSUE.
  - Requester i may drop or change req_valid/fields the cycle after req_ready[i].
- ISSUE: Transfer=1 for exactly one cycle; next state WAIT.
- WAIT:
  - Transfer=0, so the master returns to IDLE after ACCESS; the master never chains transfers.
  - On PENABLE && PREADY: capture PRDATA into rsp_rdata (write: capture anyway, value don't-care) and PSLVERR into rsp_slverr; go to RESP.
  - Watchdog counter increments each WAIT cycle, saturates, and clears on leaving WAIT. No abort; the arbiter keeps waiting.
- RESP:
  - rsp_valid[grant]=1 for one cycle; rr_ptr = (grant+1) mod NUM_REQ; next state IDLE.
  - rsp_rdata and rsp_slverr hold until the next completion.
- IN_* are stable from the ISSUE edge through completion.
- Latency, zero-wait slave: req_ready in cycle 0, Transfer in cycle 1, SETUP in cycle 2, ACCESS+PREADY in cycle 3, rsp_valid in cycle 4. Each slave wait state adds 1 cycle. Back-to-back throughput is 1 transfer per 5 cycles.
- Simultaneous requests: only one grant per IDLE visit; losers stay pending with req_ready=0.
- A requester with continuous req_valid cannot starve others; grants rotate.
- A requester whose req_valid drops before it is granted receives nothing.
- PENABLE && PREADY outside WAIT is ignored.

Decomposition:
- Shared include apb_defs.vh: state encodings (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_RESP=2'd3) and the default width constants shared with APB_BUS.
- One sub-module, rr_priority_picker: purely combinational, inputs req vector and rr_ptr, outputs one-hot grant and index.

Test Plan:
1. Reset mid-WAIT: PRESET=1 one edge while PREADY=0 -> next cycle state=IDLE, Transfer=0, busy=0, rsp_valid=0, rr_ptr=0.
2. Single write, req0 addr=4'hF data=240 strb=4'b1111, PREADY=1 in ACCESS:
   - Pulses: req_ready=2'b01 (cycle 0), Transfer=1 (cycle 1), IN_ADDR=F and IN_DATA=240 stable until completion.
   - Result: rsp_valid=2'b01 at cycle 4, rsp_slverr=0.
3. Read with 3 wait states, req1 addr=4'h1, PRDATA=15 at completion:
   - rsp_valid=2'b10 at cycle 7; rsp_rdata=15.
   - wait_timeout stays 0.
4. Contention, req_valid=2'b11 held for 4 transactions -> grant order 0,1,0,1; each rsp_valid pulse matches the grant.
5. Error and timeout, PREADY withheld 20 cycles then PREADY=1, PSLVERR=1:
   - wait_timeout=1 from the 16th WAIT cycle until completion.
   - rsp_slverr=1 on completion; no abort.
6. Request withdrawn: req1 valid 1 cycle while req0 is in WAIT, then dropped -> req1 never receives req_ready or rsp_valid.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the APB master arbiter: FSM encodings, default bus
// widths shared with APB_BUS, and the round-robin index helper.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam int APB_ADDR_WIDTH_DEF = 4;
    localparam int APB_DATA_WIDTH_DEF = 32;
    localparam int APB_STRB_WIDTH_DEF = APB_DATA_WIDTH_DEF / 8;

    // Requester index reached by stepping 'off' places up from 'base', wrapping at 'modulus'.
    function automatic int wrap_idx(input int base, input int off, input int modulus);
        int sum;
        sum = base + off;
        if (sum >= modulus) sum = sum - modulus;
        return sum;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping around, reported as a one-hot grant and a binary index.
module rr_priority_picker
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    always_comb begin : pick
        int cand;
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = wrap_idx(int'(rr_ptr), off, NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB_BUS master between NUM_REQ requesters;
// one transfer in flight at a time, response routed back to the granted requester.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
    parameter int STRB_WIDTH     = APB_STRB_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic                          Transfer,
    output logic [ADDR_WIDTH-1:0]         IN_ADDR,
    output logic [DATA_WIDTH-1:0]         IN_DATA,
    output logic                          IN_WRITE,
    output logic [STRB_WIDTH-1:0]         IN_STRB,
    input  logic                          PENABLE,
    input  logic                          PREADY,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PSLVERR,
    output logic                          busy,
    output logic                          wait_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e         state, state_next;
    logic [IDX_W-1:0]   rr_ptr, grant_idx, pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [CNT_W-1:0]   wait_cnt;
    logic               bus_done;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign bus_done = PENABLE && PREADY;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        Transfer   = 1'b0;
        case (state)
            ARB_IDLE: begin
                // A grant during reset would be lost at the edge, so never advertise one.
                if (pick_any && !PRESET) begin
                    req_ready  = pick_oh;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                Transfer   = 1'b1;
                state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus_done) state_next = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid[grant_idx] = 1'b1;
                state_next           = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            IN_ADDR    <= '0;
            IN_DATA    <= '0;
            IN_WRITE   <= 1'b0;
            IN_STRB    <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && pick_any) begin
                grant_idx <= pick_idx;
                IN_ADDR   <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                IN_DATA   <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                IN_WRITE  <= req_write[pick_idx];
                IN_STRB   <= req_strb[pick_idx*STRB_WIDTH +: STRB_WIDTH];
            end
            if (state == ARB_WAIT && bus_done) begin
                rsp_rdata  <= PRDATA;
                rsp_slverr <= PSLVERR;
            end
            if (state == ARB_RESP)
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Counts WAIT cycles including the current one; saturates, no abort.
            if (state_next == ARB_WAIT) begin
                if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign busy         = (state != ARB_IDLE);
    assign wait_timeout = (wait_cnt >= CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transactions, a behavioural
// APB_BUS/slave model, and a monitor checking grants, issue fields and responses.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int TO      = 16;

    logic                 PCLK      = 1'b0;
    logic                 PRESET    = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]   req_write = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ*SW-1:0] req_strb = '0;
    logic                 PENABLE   = 1'b0;
    logic                 PREADY    = 1'b0;
    logic [DW-1:0]        PRDATA    = '0;
    logic                 PSLVERR   = 1'b0;

    logic [NUM_REQ-1:0] req_ready, rsp_valid;
    logic [DW-1:0]      rsp_rdata, IN_DATA;
    logic [AW-1:0]      IN_ADDR;
    logic [SW-1:0]      IN_STRB;
    logic               rsp_slverr, Transfer, IN_WRITE, busy, wait_timeout;

    apb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .Transfer(Transfer), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA),
        .IN_WRITE(IN_WRITE), .IN_STRB(IN_STRB),
        .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .busy(busy), .wait_timeout(wait_timeout)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            idx;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            nwait;
        logic [DW-1:0] prdata;
        logic          pslverr;
    } txn_t;

    txn_t grant_q[$], issue_q[$], rsp_q[$], bus_q[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    bit   bus_active = 1'b0;

    always @(posedge PCLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic txn_t mk(input int idx, input logic write, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                input int nwait, input logic [DW-1:0] prdata, input logic pslverr);
        txn_t t;
        t.idx = idx; t.write = write; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.nwait = nwait; t.prdata = prdata; t.pslverr = pslverr;
        return t;
    endfunction

    // APB_BUS + slave: SETUP the cycle after Transfer, then ACCESS with nwait wait states.
    initial begin : bus_model
        txn_t b;
        forever begin
            @(negedge PCLK);
            if (Transfer && !PRESET) begin
                bus_active = 1'b1;
                if (bus_q.size() == 0) begin
                    fail_now("bus_response_missing");
                end else begin
                    b = bus_q.pop_front();
                    @(posedge PCLK); #1;
                    @(posedge PCLK); #1;
                    PENABLE = 1'b1;
                    PREADY  = 1'b0;
                    for (int w = 0; w < b.nwait; w++) begin
                        @(posedge PCLK); #1;
                    end
                    PREADY  = 1'b1;
                    PRDATA  = b.prdata;
                    PSLVERR = b.pslverr;
                    @(posedge PCLK); #1;
                    PENABLE = 1'b0;
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                    PRDATA  = '0;
                end
                bus_active = 1'b0;
            end
        end
    end

    initial begin : monitor
        txn_t t, cur;
        int   grant_cyc = 0;
        bit   in_wait   = 1'b0;
        int   k         = 0;
        bit   exp_to;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                in_wait = 1'b0;
                k       = 0;
            end else begin
                if (req_ready != '0) begin
                    if (grant_q.size() == 0) fail_now("unexpected_req_ready");
                    else begin
                        t = grant_q.pop_front();
                        check("req_ready", 64'(req_ready), 64'(oh(t.idx)));
                        grant_cyc = cyc;
                    end
                end
                exp_to = 1'b0;
                if (Transfer) begin
                    if (issue_q.size() == 0) fail_now("unexpected_transfer");
                    else begin
                        cur = issue_q.pop_front();
                        check("transfer_latency", 64'(cyc - grant_cyc), 64'(1));
                        check("in_fields", 64'({IN_WRITE, IN_STRB, IN_ADDR, IN_DATA}),
                              64'({cur.write, cur.strb, cur.addr, cur.wdata}));
                        in_wait = 1'b1;
                        k       = 0;
                    end
                end else if (in_wait) begin
                    k++;
                    exp_to = (k >= TO);
                    if (PENABLE && PREADY) in_wait = 1'b0;
                end
                check("wait_timeout", 64'(wait_timeout), 64'(exp_to));
                if (rsp_valid != '0) begin
                    if (rsp_q.size() == 0) fail_now("unexpected_rsp_valid");
                    else begin
                        t = rsp_q.pop_front();
                        check("rsp_valid", 64'(rsp_valid), 64'(oh(t.idx)));
                        check("rsp_latency", 64'(cyc - grant_cyc), 64'(4 + t.nwait));
                        check("rsp_slverr", 64'(rsp_slverr), 64'(t.pslverr));
                        if (!t.write) check("rsp_rdata", 64'(rsp_rdata), 64'(t.prdata));
                        check("in_stable", 64'({IN_ADDR, IN_DATA}), 64'({t.addr, t.wdata}));
                    end
                end
            end
        end
    end

    task automatic set_req(input txn_t t);
        req_addr[t.idx*AW +: AW]  = t.addr;
        req_wdata[t.idx*DW +: DW] = t.wdata;
        req_strb[t.idx*SW +: SW]  = t.strb;
        req_write[t.idx]          = t.write;
    endtask

    task automatic push_txn(input txn_t t);
        grant_q.push_back(t);
        issue_q.push_back(t);
        rsp_q.push_back(t);
        bus_q.push_back(t);
    endtask

    task automatic wait_ready(input int idx);
        int n = 0;
        while (n < 100) begin
            @(negedge PCLK);
            if (req_ready[idx]) break;
            n++;
        end
        if (n >= 100) fail_now("req_ready_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_active || busy) && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
        @(posedge PCLK); #1;
    endtask

    task automatic run_single(input txn_t t);
        push_txn(t);
        set_req(t);
        req_valid[t.idx] = 1'b1;
        wait_ready(t.idx);
        @(posedge PCLK); #1;
        req_valid[t.idx] = 1'b0;
        drain();
    endtask

    initial begin : main
        txn_t t, a0, a1, b0, b1;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("reset_ctrl", 64'({Transfer, busy, wait_timeout, rsp_slverr}), 64'(0));
        check("reset_handshake", 64'({req_ready, rsp_valid}), 64'(0));
        check("reset_in_bus", 64'({IN_WRITE, IN_STRB, IN_ADDR, IN_DATA}), 64'(0));
        check("reset_rdata", 64'(rsp_rdata), 64'(0));
        @(posedge PCLK); #1;

        // Single zero-wait write from requester 0.
        run_single(mk(0, 1'b1, 4'hF, 32'd240, 4'b1111, 0, 32'h0BAD_F00D, 1'b0));
        // Read from requester 1 with three slave wait states.
        run_single(mk(1, 1'b0, 4'h1, 32'd0, 4'b0000, 3, 32'd15, 1'b0));

        // Requester 1 pulses valid for one cycle while requester 0 is in WAIT.
        t = mk(0, 1'b0, 4'h2, 32'd0, 4'b0000, 4, 32'h1234_5678, 1'b0);
        push_txn(t);
        set_req(t);
        req_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge PCLK); #1;
        req_valid[0] = 1'b0;
        @(posedge PCLK); #1;
        set_req(mk(1, 1'b1, 4'hB, 32'h0000_00BB, 4'b1111, 0, 32'd0, 1'b0));
        req_valid[1] = 1'b1;
        @(negedge PCLK);
        check("withdrawn_no_ready", 64'(req_ready), 64'(0));
        @(posedge PCLK); #1;
        req_valid[1] = 1'b0;
        drain();

        // Long wait with slave error: watchdog must rise and the transfer still completes.
        run_single(mk(0, 1'b1, 4'h6, 32'hCAFE_0001, 4'b0011, 20, 32'hDEAD_BEEF, 1'b1));

        // Reset while requester 0's transfer sits in WAIT (rr_ptr is 1 here).
        t = mk(0, 1'b0, 4'hA, 32'd0, 4'b0000, 10, 32'h0000_5555, 1'b0);
        push_txn(t);
        set_req(t);
        req_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge PCLK); #1;
        req_valid[0] = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        check("midreset_ctrl", 64'({Transfer, busy, wait_timeout, rsp_slverr}), 64'(0));
        check("midreset_handshake", 64'({req_ready, rsp_valid}), 64'(0));
        check("midreset_rdata", 64'(rsp_rdata), 64'(0));
        check("midreset_in_addr", 64'(IN_ADDR), 64'(0));
        rsp_q.delete();
        begin
            int n = 0;
            while (bus_active && n < 100) begin
                @(negedge PCLK);
                n++;
            end
            if (n >= 100) fail_now("stray_bus_timeout");
        end
        @(negedge PCLK);
        check("stray_ready_ignored", 64'({busy, rsp_valid}), 64'(0));
        @(posedge PCLK); #1;

        // Contention: both requesters held valid; grants must go 0,1,0,1 from reset rr_ptr.
        a0 = mk(0, 1'b1, 4'h3, 32'h0000_0011, 4'b0001, 0, 32'd0, 1'b0);
        b0 = mk(1, 1'b0, 4'h5, 32'd0, 4'b0000, 1, 32'h0000_00A5, 1'b0);
        a1 = mk(0, 1'b0, 4'h7, 32'd0, 4'b0000, 0, 32'h0000_0077, 1'b1);
        b1 = mk(1, 1'b1, 4'h9, 32'h0000_0099, 4'b1100, 0, 32'd0, 1'b0);
        push_txn(a0);
        push_txn(b0);
        push_txn(a1);
        push_txn(b1);
        set_req(a0);
        set_req(b0);
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_ready(n % 2);
            @(posedge PCLK); #1;
            case (n)
                0:       set_req(a1);
                1:       set_req(b1);
                2:       req_valid[0] = 1'b0;
                default: req_valid[1] = 1'b0;
            endcase
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
